uart_rx: RTL and testbench

- UART receiver, 8N1, LSB first, 16 Clk cycles per bit. Clk is the 16x oversample clock shared with the UART transmitter.
- Deserialises the Rx line and presents each byte on an AXI-Stream master port to the core.
- Reports framing and overrun errors as single-cycle pulses.
- Sits between the board Rx pin and the core's receive path, mirroring the transmit path.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver, LSB first, oversampled by CYCLES_PER_BIT,
//           presenting bytes on an AXI-Stream master with error pulses.
// Revision: 1.0
// ============================================================================
module uart_rx #(
   parameter int CYCLES_PER_BIT = 16,
   parameter int SAMPLE_POINT   = CYCLES_PER_BIT / 2 - 1
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   output logic [7:0] M_axis_tdata,
   output logic       M_axis_tvalid,
   input  logic       M_axis_tready,
   output logic       Frame_err,
   output logic       Overrun_err
);

   localparam int                 c_cnt_w  = $clog2(CYCLES_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_sample = c_cnt_w'(SAMPLE_POINT);
   localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(CYCLES_PER_BIT - 1);

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_START = 5'b00010,
      ST_DATA  = 5'b00100,
      ST_STOP  = 5'b01000,
      ST_BREAK = 5'b10000
   } state_t;

   state_t               r_state;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [c_cnt_w-1:0]   r_cycle_cnt;
   logic [2:0]           r_bit_cnt;
   logic [7:0]           r_shift;
   logic [7:0]           r_tdata;
   logic                 r_tvalid;
   logic                 r_frame_err;
   logic                 r_overrun_err;
   logic                 w_deliver;

   // A good stop bit hands the byte over at mid-stop, leaving half a bit to resync.
   assign w_deliver = (r_state == ST_STOP) && (r_cycle_cnt == c_sample) && r_rx_s;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_rx_meta     <= 1'b1;
         r_rx_s        <= 1'b1;
         r_state       <= ST_IDLE;
         r_cycle_cnt   <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_tdata       <= '0;
         r_tvalid      <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_rx_meta     <= Rx;
         r_rx_s        <= r_rx_meta;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;

         if (w_deliver) begin
            if (r_tvalid && !M_axis_tready) begin
               r_overrun_err <= 1'b1;
            end else begin
               r_tdata  <= r_shift;
               r_tvalid <= 1'b1;
            end
         end else if (r_tvalid && M_axis_tready) begin
            r_tvalid <= 1'b0;
         end

         r_cycle_cnt <= r_cycle_cnt + 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_cycle_cnt <= '0;
               r_bit_cnt   <= '0;
               if (!r_rx_s) begin
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if ((r_cycle_cnt == c_sample) && r_rx_s) begin
                  r_state     <= ST_IDLE;
                  r_cycle_cnt <= '0;
               end else if (r_cycle_cnt == c_last) begin
                  r_state     <= ST_DATA;
                  r_cycle_cnt <= '0;
               end
            end
            ST_DATA: begin
               if (r_cycle_cnt == c_sample) begin
                  r_shift[r_bit_cnt] <= r_rx_s;
               end
               if (r_cycle_cnt == c_last) begin
                  r_cycle_cnt <= '0;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= ST_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (r_cycle_cnt == c_sample) begin
                  r_cycle_cnt <= '0;
                  if (r_rx_s) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               // A held-low line is one break, not a stream of zero frames.
               if (r_rx_s) begin
                  r_state     <= ST_IDLE;
                  r_cycle_cnt <= '0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cycle_cnt <= '0;
            end
         endcase
      end
   end

   assign M_axis_tdata  = r_tdata;
   assign M_axis_tvalid = r_tvalid;
   assign Frame_err     = r_frame_err;
   assign Overrun_err   = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : bench for uart_rx against a line-sampling reference model.
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

   localparam int CPB       = 16;
   localparam int MAXW      = 12000;
   localparam int LEAD      = 3;
   localparam int MID_STOP  = 9 * CPB + CPB / 2;
   localparam int STOP_EDGE = MID_STOP + 2;

   logic       Clk           = 1'b0;
   logic       Rst           = 1'b1;
   logic       Rx            = 1'b1;
   logic       M_axis_tready = 1'b0;
   logic [7:0] M_axis_tdata;
   logic       M_axis_tvalid;
   logic       Frame_err;
   logic       Overrun_err;

   uart_rx #(.CYCLES_PER_BIT(CPB)) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Rx            (Rx),
      .M_axis_tdata  (M_axis_tdata),
      .M_axis_tvalid (M_axis_tvalid),
      .M_axis_tready (M_axis_tready),
      .Frame_err     (Frame_err),
      .Overrun_err   (Overrun_err)
   );

   always #5 Clk = ~Clk;

   bit         wave    [MAXW];
   bit         rdy     [MAXW];
   bit         ev_del  [MAXW];
   logic [7:0] ev_dat  [MAXW];
   bit         ev_ferr [MAXW];
   int         wlen;
   int         passed = 0;
   int         total  = 0;
   logic [7:0] beats [$];
   int         rises [$];
   int         n_ferr;
   int         n_ovr;

   typedef struct {
      int         kind;      // 0: frame then low_len low, 1: low pulse of low_len
      logic [7:0] data;
      bit         stop_ok;
      int         low_len;
      bit         ready;
      int         exp_beats;
      logic [7:0] exp_tdata;
      int         exp_ferr;
      int         exp_rise;  // -1: tvalid never rises
   } vec_t;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endfunction

   task automatic w_put(input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         if (wlen < MAXW) begin
            wave[wlen] = v;
            wlen++;
         end
      end
   endtask

   task automatic w_frame(input logic [7:0] d, input bit stop_ok);
      w_put(1'b0, CPB);
      for (int i = 0; i < 8; i++) w_put(d[i], CPB);
      w_put(stop_ok, CPB);
   endtask

   task automatic w_begin();
      wlen = 0;
      w_put(1'b1, LEAD);
   endtask

   task automatic set_rdy(input int from, input bit v);
      for (int i = from; i < MAXW; i++) rdy[i] = v;
   endtask

   function automatic int find_level(input int from, input bit v);
      for (int t = from; t < wlen; t++) if (wave[t] == v) return t;
      return -1;
   endfunction

   // Line sample captured at cycle t drives decisions two cycles later.
   task automatic model_scan();
      int c, t0, h;
      logic [7:0] d;
      for (int i = 0; i < MAXW; i++) begin
         ev_del[i]  = 1'b0;
         ev_ferr[i] = 1'b0;
         ev_dat[i]  = '0;
      end
      c = 0;
      forever begin
         t0 = find_level(c, 1'b0);
         if (t0 < 0 || t0 + STOP_EDGE >= wlen) break;
         if (wave[t0 + CPB / 2]) begin
            c = t0 + CPB / 2 + 1;
            continue;
         end
         for (int i = 0; i < 8; i++) d[i] = wave[t0 + CPB * (i + 1) + CPB / 2];
         if (wave[t0 + MID_STOP]) begin
            ev_del[t0 + STOP_EDGE] = 1'b1;
            ev_dat[t0 + STOP_EDGE] = d;
            c = t0 + MID_STOP + 1;
         end else begin
            ev_ferr[t0 + STOP_EDGE] = 1'b1;
            h = find_level(t0 + MID_STOP + 1, 1'b1);
            if (h < 0) break;
            c = h + 1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1;
      Rx = 1'b1;
      M_axis_tready = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      check("reset_outputs", 32'({M_axis_tdata, M_axis_tvalid, Frame_err, Overrun_err}), 32'h0);
   endtask

   task automatic run_phase(input int ncyc);
      bit mv, ovr, bad, prev_v;
      logic [7:0] md;
      mv = 1'b0; md = '0; bad = 1'b0; prev_v = 1'b0;
      beats.delete(); rises.delete();
      n_ferr = 0; n_ovr = 0;
      for (int c = 0; c < ncyc; c++) begin
         Rx = wave[c];
         M_axis_tready = rdy[c];
         if (M_axis_tvalid && M_axis_tready) beats.push_back(M_axis_tdata);
         @(negedge Clk);
         ovr = 1'b0;
         if (ev_del[c]) begin
            if (mv && !rdy[c]) ovr = 1'b1;
            else begin
               mv = 1'b1;
               md = ev_dat[c];
            end
         end else if (mv && rdy[c]) begin
            mv = 1'b0;
         end
         if (M_axis_tvalid && !prev_v) rises.push_back(c);
         prev_v = M_axis_tvalid;
         n_ferr += int'(Frame_err);
         n_ovr  += int'(Overrun_err);
         if (!bad) begin
            total++;
            if ({M_axis_tvalid, M_axis_tdata, Frame_err, Overrun_err} === {mv, md, ev_ferr[c], ovr}) passed++;
            else begin
               bad = 1'b1;
               $display("FAIL cycle_model @%0d: got v=%b d=%h fe=%b oe=%b, want v=%b d=%h fe=%b oe=%b",
                        c, M_axis_tvalid, M_axis_tdata, Frame_err, Overrun_err, mv, md, ev_ferr[c], ovr);
            end
         end
      end
   endtask

   function automatic logic [7:0] beat_at(input int i);
      if (i < beats.size()) return beats[i];
      return 8'hxx;
   endfunction

   function automatic int rise_gap(input int i);
      if (i + 1 < rises.size()) return rises[i + 1] - rises[i];
      return -1;
   endfunction

   initial begin
      vec_t vecs [10];
      int   raise_at, t7e, act_rise, r;
      vecs[0] = '{0, 8'hA5, 1'b1, 0,   1'b1, 1, 8'hA5, 0, 154};
      vecs[1] = '{0, 8'h00, 1'b1, 0,   1'b1, 1, 8'h00, 0, 154};
      vecs[2] = '{0, 8'hFF, 1'b1, 0,   1'b1, 1, 8'hFF, 0, 154};
      vecs[3] = '{0, 8'h55, 1'b0, 400, 1'b1, 0, 8'h00, 1, -1};
      vecs[4] = '{1, 8'h00, 1'b1, 4,   1'b1, 0, 8'h00, 0, -1};
      vecs[5] = '{1, 8'h00, 1'b1, 12,  1'b1, 1, 8'hFF, 0, 154};
      vecs[6] = '{1, 8'h00, 1'b1, 300, 1'b1, 0, 8'h00, 1, -1};
      vecs[7] = '{0, 8'hA5, 1'b1, 0,   1'b0, 0, 8'hA5, 0, 154};
      vecs[8] = '{1, 8'h00, 1'b1, 8,   1'b1, 0, 8'h00, 0, -1};
      vecs[9] = '{1, 8'h00, 1'b1, 9,   1'b1, 1, 8'hFF, 0, 154};

      for (int k = 0; k < 10; k++) begin
         w_begin();
         if (vecs[k].kind == 0) w_frame(vecs[k].data, vecs[k].stop_ok);
         w_put(1'b0, vecs[k].low_len);
         w_put(1'b1, 200);
         set_rdy(0, vecs[k].ready);
         model_scan();
         do_reset();
         run_phase(wlen);
         act_rise = (rises.size() == 0) ? -1 : rises[0] - LEAD;
         check($sformatf("v%0d_beats", k), beats.size(), vecs[k].exp_beats);
         check($sformatf("v%0d_tdata", k), 32'(M_axis_tdata), 32'(vecs[k].exp_tdata));
         check($sformatf("v%0d_ferr", k), n_ferr, vecs[k].exp_ferr);
         check($sformatf("v%0d_rise", k), act_rise, vecs[k].exp_rise);
      end

      // back-to-back frames, stop bit of exactly one bit time
      w_begin();
      w_frame(8'h00, 1'b1); w_frame(8'hFF, 1'b1); w_frame(8'h3C, 1'b1);
      w_put(1'b1, 200);
      set_rdy(0, 1'b1);
      model_scan(); do_reset(); run_phase(wlen);
      check("btb_count", beats.size(), 3);
      check("btb_b0", 32'(beat_at(0)), 32'h00);
      check("btb_b1", 32'(beat_at(1)), 32'hFF);
      check("btb_b2", 32'(beat_at(2)), 32'h3C);
      check("btb_gap0", rise_gap(0), 160);
      check("btb_gap1", rise_gap(1), 160);

      // overrun while stalled, then drain
      w_begin();
      w_frame(8'h11, 1'b1); w_frame(8'h22, 1'b1);
      w_put(1'b1, 100);
      raise_at = wlen;
      w_put(1'b1, 100);
      set_rdy(0, 1'b0); set_rdy(raise_at, 1'b1);
      model_scan(); do_reset(); run_phase(wlen);
      check("ovr_pulses", n_ovr, 1);
      check("ovr_count", beats.size(), 1);
      check("ovr_b0", 32'(beat_at(0)), 32'h11);
      check("ovr_tdata", 32'(M_axis_tdata), 32'h11);
      check("ovr_tvalid_drop", 32'(M_axis_tvalid), 32'h0);

      // break: bad stop, line held low, then a clean frame
      w_begin();
      w_frame(8'h55, 1'b0); w_put(1'b0, 400); w_put(1'b1, 20);
      w_frame(8'h12, 1'b1); w_put(1'b1, 200);
      set_rdy(0, 1'b1);
      model_scan(); do_reset(); run_phase(wlen);
      check("brk_ferr", n_ferr, 1);
      check("brk_count", beats.size(), 1);
      check("brk_b0", 32'(beat_at(0)), 32'h12);
      check("brk_ovr", n_ovr, 0);

      // reset during data bit 3 while a byte is held
      w_begin();
      w_frame(8'h33, 1'b1); w_put(1'b1, 10);
      t7e = wlen;
      w_frame(8'h7E, 1'b1); w_put(1'b1, 200);
      set_rdy(0, 1'b0);
      model_scan(); do_reset(); run_phase(t7e + 2 + CPB + 3 * CPB + CPB / 2);
      check("rst_pre_hold", 32'({M_axis_tvalid, M_axis_tdata}), 32'h133);
      do_reset();
      w_begin();
      w_frame(8'h81, 1'b1); w_put(1'b1, 200);
      set_rdy(0, 1'b1);
      model_scan(); run_phase(wlen);
      check("rst_count", beats.size(), 1);
      check("rst_b0", 32'(beat_at(0)), 32'h81);
      check("rst_ferr", n_ferr, 0);

      // loopback sweep of every byte value
      for (int base = 0; base < 256; base += 64) begin
         w_begin();
         for (int j = 0; j < 64; j++) w_frame(8'(base + j), 1'b1);
         w_put(1'b1, 200);
         set_rdy(0, 1'b1);
         model_scan(); do_reset(); run_phase(wlen);
         check($sformatf("loop%0d_count", base), beats.size(), 64);
         for (int j = 0; j < 64; j++)
            check($sformatf("loop_%0d", base + j), 32'(beat_at(j)), base + j);
         check($sformatf("loop%0d_ferr", base), n_ferr, 0);
      end

      // randomized traffic: glitches, bad stops, gaps, random back-pressure
      for (int p = 0; p < 3; p++) begin
         w_begin();
         while (wlen < 6000) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
               w_put(1'b0, $urandom_range(1, 8));
               w_put(1'b1, $urandom_range(10, 30));
            end else if (r == 1) begin
               w_frame(8'($urandom), 1'b0);
               w_put(1'b0, $urandom_range(0, 50));
               w_put(1'b1, $urandom_range(20, 40));
            end else begin
               w_frame(8'($urandom), 1'b1);
               w_put(1'b1, $urandom_range(0, 40));
            end
         end
         w_put(1'b1, 200);
         for (int i = 0; i < MAXW; i++) rdy[i] = ($urandom_range(0, 3) != 0);
         model_scan(); do_reset(); run_phase(wlen);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
